// File: rtl/elevator_emergency_pkg.sv
// rtl/elevator_emergency_pkg.sv - shared state encoding, default constants and counter sizing helper
package elevator_emergency_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ALARM       = 3'd1,
        ST_RESET_PULSE = 3'd2,
        ST_VERIFY      = 3'd3,
        ST_FAULT       = 3'd4
    } ow_state_e;

    localparam int DEF_DEBOUNCE_CYCLES    = 4;
    localparam int DEF_RESET_PULSE_CYCLES = 2;
    localparam int DEF_VERIFY_TIMEOUT     = 8;

    // A counter that spans 0..n-1 needs $clog2(n) bits; keep at least one bit for n == 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/overweight_handler_if.sv
// rtl/overweight_handler_if.sv - weight_control / sensor / actuator signal bundle
interface overweight_handler_if;
    logic weight_limit_exceeded;
    logic load_ok;
    logic weight_flip_reset;
    logic door_hold_open;
    logic motion_inhibit;
    logic alarm;
    logic fault;

    modport master (
        input  weight_limit_exceeded,
        input  load_ok,
        output weight_flip_reset,
        output door_hold_open,
        output motion_inhibit,
        output alarm,
        output fault
    );

    modport slave (
        output weight_limit_exceeded,
        output load_ok,
        input  weight_flip_reset,
        input  door_hold_open,
        input  motion_inhibit,
        input  alarm,
        input  fault
    );
endinterface

// File: rtl/level_debounce.sv
// rtl/level_debounce.sv - accepts a level after CYCLES consecutive high samples
module level_debounce
    import elevator_emergency_pkg::*;
#(
    parameter int CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic level,
    output logic accepted
);
    localparam int            CW   = cnt_width(CYCLES);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] count;

    // Count saturates at LAST so a long-held level keeps reporting accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || !level) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + 1'b1;
        end
    end

    assign accepted = level && (count == LAST);
endmodule

// File: rtl/overweight_handler.sv
// rtl/overweight_handler.sv - overweight alarm / clear / verify sequencer
// Optional alarm blinking in ALARM and FAULT is enabled with `define OVERWEIGHT_BLINK_EN.
module overweight_handler
    import elevator_emergency_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = DEF_DEBOUNCE_CYCLES,
    parameter int RESET_PULSE_CYCLES = DEF_RESET_PULSE_CYCLES,
    parameter int VERIFY_TIMEOUT     = DEF_VERIFY_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    overweight_handler_if.master bus
);
    localparam int            PW         = cnt_width(RESET_PULSE_CYCLES);
    localparam int            VW         = cnt_width(VERIFY_TIMEOUT);
    localparam logic [PW-1:0] PULSE_LAST = PW'(RESET_PULSE_CYCLES - 1);
    localparam logic [VW-1:0] VERIFY_LAST = VW'(VERIFY_TIMEOUT - 1);

    ow_state_e     state, next_state;
    logic [PW-1:0] pulse_cnt;
    logic [VW-1:0] verify_cnt;
    logic          weight_acc, load_acc;
    logic          flip_d, hold_d, inhibit_d, alarm_d, fault_d, alarm_gate;

    // Each debouncer only counts in the state that consumes it, so entry always starts from zero.
    level_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_weight_db (
        .clk      (clk),
        .reset    (reset),
        .clear    (state != ST_IDLE),
        .level    (bus.weight_limit_exceeded),
        .accepted (weight_acc)
    );

    level_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_load_db (
        .clk      (clk),
        .reset    (reset),
        .clear    (state != ST_ALARM),
        .level    (bus.load_ok),
        .accepted (load_acc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (weight_acc) next_state = ST_ALARM;
            end
            ST_ALARM: begin
                if (!bus.weight_limit_exceeded) next_state = ST_IDLE;
                else if (load_acc)              next_state = ST_RESET_PULSE;
            end
            ST_RESET_PULSE: begin
                if (pulse_cnt == PULSE_LAST) next_state = ST_VERIFY;
            end
            ST_VERIFY: begin
                if (!bus.load_ok)                    next_state = ST_ALARM;
                else if (!bus.weight_limit_exceeded) next_state = ST_IDLE;
                else if (verify_cnt == VERIFY_LAST)  next_state = ST_FAULT;
            end
            ST_FAULT: begin
                next_state = ST_FAULT;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from next_state and registered, so they track the state register exactly.
    always_comb begin
        flip_d    = (next_state == ST_RESET_PULSE);
        hold_d    = (next_state != ST_IDLE);
        inhibit_d = (next_state != ST_IDLE);
        alarm_d   = (next_state == ST_ALARM) || (next_state == ST_FAULT);
        fault_d   = (next_state == ST_FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_cnt  <= '0;
            verify_cnt <= '0;
        end else begin
            if (state != ST_RESET_PULSE)  pulse_cnt <= '0;
            else if (pulse_cnt != PULSE_LAST) pulse_cnt <= pulse_cnt + 1'b1;

            if (state != ST_VERIFY)             verify_cnt <= '0;
            else if (verify_cnt != VERIFY_LAST) verify_cnt <= verify_cnt + 1'b1;
        end
    end

`ifdef OVERWEIGHT_BLINK_EN
    logic [1:0] blink_cnt;
    logic       blink_on, blink_on_d, blink_state, blink_entry;

    assign blink_state = (next_state == ST_ALARM) || (next_state == ST_FAULT);
    assign blink_entry = blink_state && (next_state != state);

    always_comb begin
        blink_on_d = 1'b1;
        if (blink_state && !blink_entry) begin
            blink_on_d = (blink_cnt == 2'd3) ? ~blink_on : blink_on;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= 2'd0;
            blink_on  <= 1'b0;
        end else begin
            blink_on <= blink_on_d;
            if (!blink_state || blink_entry) blink_cnt <= 2'd0;
            else                             blink_cnt <= (blink_cnt == 2'd3) ? 2'd0 : blink_cnt + 2'd1;
        end
    end

    assign alarm_gate = blink_on_d;
`else
    assign alarm_gate = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.weight_flip_reset <= 1'b0;
            bus.door_hold_open    <= 1'b0;
            bus.motion_inhibit    <= 1'b0;
            bus.alarm             <= 1'b0;
            bus.fault             <= 1'b0;
        end else begin
            bus.weight_flip_reset <= flip_d;
            bus.door_hold_open    <= hold_d;
            bus.motion_inhibit    <= inhibit_d;
            bus.alarm             <= alarm_d & alarm_gate;
            bus.fault             <= fault_d;
        end
    end
endmodule

// File: tb/tb_overweight_handler.sv
// tb/tb_overweight_handler.sv - directed self-checking bench for overweight_handler
module tb_overweight_handler;
    logic clk = 1'b0;
    logic reset;

    overweight_handler_if bus ();

    overweight_handler #(
        .DEBOUNCE_CYCLES    (4),
        .RESET_PULSE_CYCLES (2),
        .VERIFY_TIMEOUT     (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {fault, alarm, motion_inhibit, door_hold_open, weight_flip_reset}
    localparam logic [4:0] O_IDLE   = 5'b00000;
    localparam logic [4:0] O_ALARM  = 5'b01110;
    localparam logic [4:0] O_PULSE  = 5'b00111;
    localparam logic [4:0] O_VERIFY = 5'b00110;
    localparam logic [4:0] O_FAULT  = 5'b11110;

    wire [4:0] outs = {bus.fault, bus.alarm, bus.motion_inhibit, bus.door_hold_open, bus.weight_flip_reset};

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic l);
        bus.weight_limit_exceeded = w;
        bus.load_ok               = l;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0);
        tick(2);
        check("reset_state", outs, O_IDLE);
        reset = 1'b0;

        // Short overweight glitch, then a restart that must count from zero.
        drive(1'b1, 1'b0);
        tick(3);
        check("glitch_3cyc_idle", outs, O_IDLE);
        drive(1'b0, 1'b0);
        tick(1);
        check("glitch_dropped_idle", outs, O_IDLE);
        drive(1'b1, 1'b0);
        tick(3);
        check("restart_3cyc_idle", outs, O_IDLE);
        tick(1);
        check("alarm_after_4", outs, O_ALARM);

        // load_ok dropout restarts the acceptance count.
        drive(1'b1, 1'b1);
        tick(3);
        check("load_3cyc_alarm", outs, O_ALARM);
        drive(1'b1, 1'b0);
        tick(1);
        check("load_dropout_alarm", outs, O_ALARM);
        drive(1'b1, 1'b1);
        tick(3);
        check("load_restart_alarm", outs, O_ALARM);
        tick(1);
        check("pulse_cycle1", outs, O_PULSE);
        tick(1);
        check("pulse_cycle2", outs, O_PULSE);
        tick(1);
        check("verify_after_pulse", outs, O_VERIFY);

        // Weight clears on the first VERIFY cycle.
        drive(1'b0, 1'b1);
        tick(1);
        check("verify_clear_idle", outs, O_IDLE);

        // Weight drop wins over load acceptance in the same ALARM cycle.
        drive(1'b1, 1'b1);
        tick(4);
        check("alarm_again", outs, O_ALARM);
        tick(3);
        drive(1'b0, 1'b1);
        tick(1);
        check("alarm_drop_priority", outs, O_IDLE);

        // Timeout into sticky FAULT.
        drive(1'b1, 1'b0);
        tick(4);
        drive(1'b1, 1'b1);
        tick(4);
        check("pulse_before_fault", outs, O_PULSE);
        tick(2);
        tick(7);
        check("verify_7cyc", outs, O_VERIFY);
        tick(1);
        check("fault_after_8", outs, O_FAULT);
        drive(1'b0, 1'b0);
        tick(5);
        check("fault_sticky", outs, O_FAULT);
        reset = 1'b1;
        #1;
        check("fault_async_reset", outs, O_IDLE);
        tick(1);
        reset = 1'b0;

        // Reset during the first pulse cycle clears outputs without a clock edge.
        drive(1'b1, 1'b0);
        tick(4);
        drive(1'b1, 1'b1);
        tick(4);
        check("pulse_before_reset", outs, O_PULSE);
        reset = 1'b1;
        #2;
        check("pulse_async_reset", outs, O_IDLE);
        tick(1);
        reset = 1'b0;
        tick(3);
        check("post_reset_3cyc_idle", outs, O_IDLE);
        tick(1);
        check("post_reset_alarm", outs, O_ALARM);

        // load_ok falls on VERIFY cycle 3 -> back to ALARM with a fresh debounce.
        tick(4);
        check("pulse_for_verify3", outs, O_PULSE);
        tick(2);
        check("verify_entry", outs, O_VERIFY);
        tick(2);
        check("verify_cycle2", outs, O_VERIFY);
        drive(1'b1, 1'b0);
        tick(1);
        check("verify_load_drop_alarm", outs, O_ALARM);
        drive(1'b1, 1'b1);
        tick(3);
        check("realarm_3cyc", outs, O_ALARM);
        tick(1);
        check("realarm_pulse", outs, O_PULSE);

        // load_ok drop beats timeout on the eighth VERIFY cycle.
        tick(2);
        check("verify_entry2", outs, O_VERIFY);
        tick(7);
        drive(1'b1, 1'b0);
        tick(1);
        check("load_drop_over_timeout", outs, O_ALARM);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/overweight_handler.md
OVERWEIGHT_HANDLER -- requirements
Module: overweight_handler

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive cycles a level input must hold before it is accepted.
REQ-002 SHALL have parameter RESET_PULSE_CYCLES, default 2: width of the weight_flip_reset pulse.
REQ-003 SHALL have parameter VERIFY_TIMEOUT, default 8: cycles allowed for weight_limit_exceeded to clear after the pulse.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port weight_limit_exceeded, input, 1 bit: level from weight_control, synchronous to clk.
REQ-007 SHALL have port load_ok, input, 1 bit: sensor level, 1 = cabin load below threshold.
REQ-008 SHALL have port weight_flip_reset, output, 1 bit: clear pulse returned to weight_control.
REQ-009 SHALL have port door_hold_open, output, 1 bit: forces the doors open.
REQ-010 SHALL have port motion_inhibit, output, 1 bit: blocks car motion.
REQ-011 SHALL have port alarm, output, 1 bit: overweight indication.
REQ-012 SHALL have port fault, output, 1 bit: sticky failure flag.

Function
REQ-013 SHALL implement FSM states IDLE, ALARM, RESET_PULSE, VERIFY, FAULT, with all outputs registered.
REQ-014 IDLE: all outputs 0; SHALL go to ALARM once weight_limit_exceeded=1 for DEBOUNCE_CYCLES consecutive cycles; any 0 restarts the count.
REQ-015 ALARM: alarm, door_hold_open, motion_inhibit=1; SHALL go to RESET_PULSE once load_ok=1 for DEBOUNCE_CYCLES consecutive cycles; a dropout restarts the count.
REQ-016 ALARM: if weight_limit_exceeded falls to 0 before load_ok is accepted, SHALL return to IDLE without a pulse; this check has priority over load_ok acceptance in the same cycle.
REQ-017 RESET_PULSE: weight_flip_reset=1 for exactly RESET_PULSE_CYCLES cycles; door_hold_open and motion_inhibit stay 1 and alarm=0; then SHALL go to VERIFY.
REQ-018 VERIFY: door_hold_open and motion_inhibit stay 1; on the first cycle weight_limit_exceeded=0, SHALL go to IDLE, and outputs release on the following edge.
REQ-019 VERIFY: if weight_limit_exceeded stays 1 for VERIFY_TIMEOUT cycles, SHALL go to FAULT.
REQ-020 VERIFY: if load_ok=0 at any cycle, SHALL go back to ALARM with its debounce count cleared; this has priority over timeout.
REQ-021 FAULT: fault, alarm and motion_inhibit=1, door_hold_open=1; sticky, exited only by reset.
REQ-022 Counters SHALL be $clog2-sized to their parameter and saturate; they SHALL never wrap.

Reset
REQ-023 reset=1 SHALL immediately force state IDLE, clear all counters, and drive all outputs to 0, including mid-pulse and in FAULT.
REQ-024 The first state evaluation SHALL occur on the first rising clk edge after reset deasserts.

Configuration
REQ-025 With OVERWEIGHT_BLINK_EN defined, alarm SHALL toggle every 4 cycles while in ALARM and FAULT, starting at 1 on state entry.
REQ-026 Without OVERWEIGHT_BLINK_EN, alarm SHALL be a steady level, and no blink counter SHALL be synthesized.

Structure
REQ-027 The state encoding and the default parameter constants SHALL live in the shared package elevator_emergency_pkg.
REQ-028 Debounce SHALL be one reusable sub-module, level_debounce, instantiated twice (weight_limit_exceeded, load_ok); the FSM and pulse/timeout counters stay in overweight_handler.

Verification (defaults 4/2/8, blink off)
REQ-029 Scenario: weight_limit_exceeded=1 for 3 cycles then 0 -> state stays IDLE, all outputs 0.
REQ-030 Scenario: weight_limit_exceeded held 1 -> alarm, door_hold_open, motion_inhibit rise after 4 cycles; load_ok=1 for 4 cycles -> weight_flip_reset high exactly 2 cycles.
REQ-031 Scenario: after the pulse, weight_limit_exceeded drops on VERIFY cycle 1 -> IDLE, motion_inhibit 0 one edge later.
REQ-032 Scenario: weight_limit_exceeded held 1 through VERIFY -> fault=1 after 8 cycles; it remains 1 until reset, then all outputs 0.
REQ-033 Scenario: reset asserted during cycle 1 of RESET_PULSE -> weight_flip_reset 0 immediately without waiting for clk.
REQ-034 Scenario: load_ok falls to 0 in VERIFY cycle 3 -> return to ALARM, alarm=1, no fault.
